// File: rtl/red_pitaya_pfd_pkg.sv
// Shared types, default widths and helpers for the PFD frequency-measurement path.
package red_pitaya_pfd_pkg;

  localparam int DEF_SIGNALBITS = 14;
  localparam int DEF_GATEBITS   = 16;
  localparam int DEF_ACCBITS    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // Two's-complement add overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/red_pitaya_pfd_wrapdiff.sv
// Combinational modular difference of two phase words; the result wraps and is read as signed.
module red_pitaya_pfd_wrapdiff
  import red_pitaya_pfd_pkg::*;
#(
  parameter int SIGNALBITS = DEF_SIGNALBITS
) (
  input  logic        [SIGNALBITS-1:0] minuend,
  input  logic        [SIGNALBITS-1:0] subtrahend,
  output logic signed [SIGNALBITS-1:0] diff
);

  assign diff = minuend - subtrahend;

endmodule

// File: rtl/red_pitaya_pfd_freq_block.sv
// Gated phase-difference accumulator producing one frequency estimate per window.
// Optional build macro PFD_FREQ_SAT_EN: accumulator saturates instead of wrapping.
module red_pitaya_pfd_freq_block
  import red_pitaya_pfd_pkg::*;
#(
  parameter int SIGNALBITS = DEF_SIGNALBITS,
  parameter int GATEBITS   = DEF_GATEBITS,
  parameter int ACCBITS    = DEF_ACCBITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [GATEBITS-1:0] gate_len_i,
  input  logic [SIGNALBITS-1:0] phase_i,
  output logic [ACCBITS-1:0]  freq_o,
  output logic                freq_valid_o,
  output logic                busy_o,
  output logic                ovf_o
);

  localparam logic [ACCBITS-1:0] ACC_MAX = {1'b0, {(ACCBITS-1){1'b1}}};
  localparam logic [ACCBITS-1:0] ACC_MIN = {1'b1, {(ACCBITS-1){1'b0}}};

  state_t                      state;
  logic        [SIGNALBITS-1:0] prev;
  logic        [GATEBITS-1:0]   len_q;
  logic        [GATEBITS-1:0]   cnt;
  logic signed [ACCBITS-1:0]    acc;
  logic                         ovf_acc;

  logic signed [SIGNALBITS-1:0] delta;
  logic signed [ACCBITS-1:0]    delta_ext;
  logic signed [ACCBITS-1:0]    sum_raw;
  logic signed [ACCBITS-1:0]    sum;
  logic                         step_ovf;
  logic        [GATEBITS-1:0]   gate_len_eff;
  logic                         last;

  red_pitaya_pfd_wrapdiff #(
    .SIGNALBITS(SIGNALBITS)
  ) u_wrapdiff (
    .minuend   (phase_i),
    .subtrahend(prev),
    .diff      (delta)
  );

  always_comb begin
    delta_ext    = {{(ACCBITS-SIGNALBITS){delta[SIGNALBITS-1]}}, delta};
    sum_raw      = acc + delta_ext;
    step_ovf     = add_ovf(acc[ACCBITS-1], delta_ext[ACCBITS-1], sum_raw[ACCBITS-1]);
`ifdef PFD_FREQ_SAT_EN
    // Clamp to the rail on the operand sign; a rail value only moves on a delta pointing away.
    if (step_ovf)
      sum = acc[ACCBITS-1] ? ACC_MIN : ACC_MAX;
    else
      sum = sum_raw;
`else
    sum = sum_raw;
`endif
    gate_len_eff = (gate_len_i == '0) ? GATEBITS'(1) : gate_len_i;
    last         = (cnt == len_q - GATEBITS'(1));
  end

  assign busy_o = (state == GATE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      prev         <= '0;
      len_q        <= GATEBITS'(1);
      cnt          <= '0;
      acc          <= '0;
      ovf_acc      <= 1'b0;
      freq_o       <= '0;
      freq_valid_o <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      freq_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            prev    <= phase_i;
            len_q   <= gate_len_eff;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            state   <= GATE;
          end
        end
        GATE: begin
          if (last) begin
            // Final sample completes the gate even if enable drops on this edge.
            freq_o       <= sum;
            ovf_o        <= ovf_acc | step_ovf;
            freq_valid_o <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
            ovf_acc      <= 1'b0;
            len_q        <= gate_len_eff;
            prev         <= phase_i;
            if (!enable_i)
              state <= IDLE;
          end else if (!enable_i) begin
            state <= IDLE;
          end else begin
            acc     <= sum;
            cnt     <= cnt + GATEBITS'(1);
            prev    <= phase_i;
            ovf_acc <= ovf_acc | step_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
